uart_baud_sched: RTL and testbench
==================================

Name: uart_baud_sched

Overview:
Programmable baud scheduler for the UART side of the UART/SPI bridge. It owns the clock divisor and generates the 16x oversample tick. It also derives the per-bit tick for the transmitter and the mid-bit sample tick for the receiver, aligned to a start-bit event. Divisor changes are accepted through a valid/ready handshake and take effect only on a tick boundary, so no shortened or glitched tick period is ever produced.

Parameters:
DIV_W, 16, width of divisor and clock-cycle counter
DEFAULT_DIV, 10, divisor loaded at reset (clocks per tick_16x)
OVERSAMPLE, 16, tick_16x pulses per UART bit (power of two)
SAMPLE_PHASE, 7, rx phase at which the bit is sampled (0..OVERSAMPLE-1)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
en  in  1  run enable; 0 freezes all counters, no ticks
cfg_valid  in  1  divisor update request
cfg_div  in  DIV_W  requested divisor
cfg_ready  out  1  high when no update is pending
cfg_err  out  1  one-cycle pulse: rejected divisor (<2)
cur_div  out  DIV_W  divisor currently in effect
tick_16x  out  1  one-cycle oversample tick
tx_bit_tick  out  1  one-cycle bit tick for TX, coincident with tick_16x
rx_start  in  1  start-bit detected pulse (re-aligns RX phase)
rx_stop  in  1  end of RX frame; stops rx sampling
rx_sample_tick  out  1  one-cycle mid-bit sample strobe, coincident with tick_16x

Behaviour:
- Reset (rst=0, async):
  - cnt=0, cur_div=DEFAULT_DIV, no pending update, cfg_ready=1.
  - tx_phase=0, rx_run=0, rx_phase=0.
  - All tick outputs and cfg_err =0.
- Clock counter cnt:
  - Counts 0..cur_div-1 while en=1. "wrap" is the cycle in which cnt==cur_div-1; cnt goes to 0 on the next edge.
  - All ticks are registered: tick_16x=1 for exactly the one cycle after each wrap, else 0.
  - Period is exactly cur_div clocks. First tick_16x occurs at clock edge cur_div after en rises (cnt starting at 0).
- en=0:
  - cnt, tx_phase and rx_phase hold their values. All ticks are 0.
  - Handshake still operates; a pending update applies immediately (next edge) and cnt is cleared.
- Config handshake:
  - Transfer occurs when cfg_valid&&cfg_ready.
  - cfg_div<2: not stored; cfg_err=1 on the next cycle; cfg_ready stays 1.
  - Otherwise: value latched as pending and cfg_ready=0 from the next cycle.
  - The pending value loads into cur_div on the next wrap (or immediately if en=0). cnt restarts at 0 with the new divisor, and cfg_ready returns to 1 on the following cycle.
  - A wrap in the same cycle as the transfer does not apply the new value; it applies at the following wrap.
- tx_phase:
  - Increments mod OVERSAMPLE on every wrap.
  - tx_bit_tick is asserted with the tick_16x produced by the wrap where tx_phase goes OVERSAMPLE-1→0, i.e. on every 16th tick_16x.
- RX alignment:
  - rx_start sets rx_run=1 and rx_phase=0, with priority over everything. A wrap in the same cycle is not counted for RX.
  - rx_start while rx_run=1 re-aligns.
  - While rx_run=1, each wrap increments rx_phase mod OVERSAMPLE.
  - rx_sample_tick is asserted with the tick_16x of the wrap where rx_phase goes SAMPLE_PHASE→SAMPLE_PHASE+1. This gives the (SAMPLE_PHASE+1)th, then every OVERSAMPLE-th, tick after rx_start.
  - rx_stop clears rx_run. rx_stop and rx_start in the same cycle: rx_start wins.
- Phase counters are not reset by divisor changes.
- cur_div is a registered output, changing only at the apply point.

Decomposition:
- Package uart_pkg:
  - DIV_W, DEFAULT_DIV, OVERSAMPLE, SAMPLE_PHASE defaults.
  - localparam PH_W=$clog2(OVERSAMPLE).
  - MIN_DIV=2 constant.
- Sub-module uart_os_phase: PH_W-bit mod-OVERSAMPLE counter with ports inc, clr, run, match value, and a registered match pulse. It is instantiated twice:
  - TX: run tied to 1, match at OVERSAMPLE-1.
  - RX: clr=rx_start, match at SAMPLE_PHASE.

Test Plan:
- Reset release, en=1, no cfg -> tick_16x high at cycles 10, 20, 30… (period 10); tx_bit_tick first at cycle 160, then every 160; cur_div=10.
- Mid-count (cnt=4), cfg_div=4 handshake -> cfg_ready low; last old-period tick at 10, then ticks every 4 clocks (14, 18…); cur_div=4 after the wrap; cfg_ready=1 one cycle later.
- cfg_div=1 and cfg_div=0 -> cfg_err one-cycle pulse each; cfg_ready stays 1; tick period and cur_div unchanged at 10.
- rx_start at cycle 0 (div 10) -> rx_sample_tick on the 8th tick_16x (~cycle 80), then 24th and 40th; rx_stop after the 40th -> no more samples; second rx_start mid-bit re-aligns to 8 ticks later.
- en dropped for 25 cycles at cnt=6, then restored -> no ticks while low; next tick 4 clocks after en returns; tx/rx phases preserved (bit tick count continues).
- rst asserted asynchronously mid-period with an update pending -> all outputs 0 immediately, cur_div=10, cfg_ready=1, rx_run=0; first tick 10 cycles after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared defaults for the UART baud scheduler slice.
package uart_pkg;

   localparam int unsigned UART_DIV_W        = 16;
   localparam int unsigned UART_DEFAULT_DIV  = 10;
   localparam int unsigned UART_OVERSAMPLE   = 16;
   localparam int unsigned UART_SAMPLE_PHASE = 7;
   localparam int unsigned PH_W              = $clog2(UART_OVERSAMPLE);
   localparam int unsigned MIN_DIV           = 2;

endpackage

// File: rtl/uart_os_phase.sv
// Mod-2^W oversample phase counter with a registered pulse on leaving the match phase.
module uart_os_phase
   import uart_pkg::*;
#(
   parameter int unsigned W = PH_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   input  logic         run,
   input  logic [W-1:0] match,
   output logic         hit
);

   logic [W-1:0] phase;

   // clr wins over a coincident inc, so that increment is dropped entirely
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
         hit   <= 1'b0;
      end else begin
         hit <= 1'b0;
         if (clr) begin
            phase <= '0;
         end else if (run && inc) begin
            phase <= phase + W'(1);
            hit   <= (phase == match);
         end
      end
   end

endmodule

// File: rtl/uart_baud_sched.sv
// Baud scheduler: divisor counter, 16x tick, TX bit tick and RX mid-bit sample tick,
// with divisor updates applied only on a tick boundary.
module uart_baud_sched
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W        = UART_DIV_W,
   parameter int unsigned DEFAULT_DIV  = UART_DEFAULT_DIV,
   parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
   parameter int unsigned SAMPLE_PHASE = UART_SAMPLE_PHASE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] cur_div,
   output logic             tick_16x,
   output logic             tx_bit_tick,
   input  logic             rx_start,
   input  logic             rx_stop,
   output logic             rx_sample_tick
);

   localparam int unsigned PHASE_W = $clog2(OVERSAMPLE);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] pend_div;
   logic             pend;
   logic             rx_run;
   logic             wrap;
   logic             take;
   logic             div_bad;
   logic             apply;

   always_comb begin
      wrap    = en && (cnt == cur_div - DIV_W'(1));
      take    = cfg_valid && cfg_ready;
      div_bad = (cfg_div < DIV_W'(MIN_DIV));
      apply   = pend && (wrap || !en);
   end

   // cfg_ready follows the pending flag one cycle late, so it reopens the cycle after apply
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         cur_div   <= DIV_W'(DEFAULT_DIV);
         pend_div  <= '0;
         pend      <= 1'b0;
         cfg_ready <= 1'b1;
         cfg_err   <= 1'b0;
         tick_16x  <= 1'b0;
      end else begin
         tick_16x  <= wrap;
         cfg_err   <= take && div_bad;
         cfg_ready <= !pend && !(take && !div_bad);

         if (take && !div_bad) begin
            pend     <= 1'b1;
            pend_div <= cfg_div;
         end

         if (apply) begin
            cur_div <= pend_div;
            pend    <= 1'b0;
            cnt     <= '0;
         end else if (en) begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_run <= 1'b0;
      end else if (rx_start) begin
         rx_run <= 1'b1;
      end else if (rx_stop) begin
         rx_run <= 1'b0;
      end
   end

   uart_os_phase #(.W(PHASE_W)) u_tx_phase (
      .clk   (clk),
      .rst   (rst),
      .inc   (wrap),
      .clr   (1'b0),
      .run   (1'b1),
      .match (PHASE_W'(OVERSAMPLE - 1)),
      .hit   (tx_bit_tick)
   );

   uart_os_phase #(.W(PHASE_W)) u_rx_phase (
      .clk   (clk),
      .rst   (rst),
      .inc   (wrap),
      .clr   (rx_start),
      .run   (rx_run),
      .match (PHASE_W'(SAMPLE_PHASE)),
      .hit   (rx_sample_tick)
   );

endmodule

// File: tb/tb_uart_baud_sched.sv
// Directed bench for uart_baud_sched; edge numbers count rising edges after reset release.
module tb_uart_baud_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [15:0] cfg_div = '0;
   logic        cfg_ready;
   logic        cfg_err;
   logic [15:0] cur_div;
   logic        tick_16x;
   logic        tx_bit_tick;
   logic        rx_start = 1'b0;
   logic        rx_stop = 1'b0;
   logic        rx_sample_tick;

   int total = 0;
   int bad = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   uart_baud_sched #(
      .DIV_W(16), .DEFAULT_DIV(10), .OVERSAMPLE(16), .SAMPLE_PHASE(7)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .cfg_valid      (cfg_valid),
      .cfg_div        (cfg_div),
      .cfg_ready      (cfg_ready),
      .cfg_err        (cfg_err),
      .cur_div        (cur_div),
      .tick_16x       (tick_16x),
      .tx_bit_tick    (tx_bit_tick),
      .rx_start       (rx_start),
      .rx_stop        (rx_stop),
      .rx_sample_tick (rx_sample_tick)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
      end
   endtask

   task automatic goto(input int k);
      while (edge_n < k) begin
         @(posedge clk);
         #1;
         edge_n++;
      end
   endtask

   task automatic do_reset(input logic en_v, input logic start_v);
      en = 1'b0; cfg_valid = 1'b0; rx_start = 1'b0; rx_stop = 1'b0;
      #3 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_div", 32'(cur_div), 32'd10);
      chk("rst_tick", 32'(tick_16x), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; en = en_v; rx_start = start_v; edge_n = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Free-running ticks at default divisor, TX bit tick every 16th
      do_reset(1'b1, 1'b0);
      goto(9);   chk("t1_tick9", 32'(tick_16x), 32'd0);
      goto(10);  chk("t1_tick10", 32'(tick_16x), 32'd1);
      chk("t1_div", 32'(cur_div), 32'd10);
      goto(11);  chk("t1_tick11", 32'(tick_16x), 32'd0);
      goto(150); chk("t1_tick150", 32'(tick_16x), 32'd1);
      chk("t1_bit150", 32'(tx_bit_tick), 32'd0);
      goto(160); chk("t1_bit160", 32'(tx_bit_tick), 32'd1);
      goto(161); chk("t1_bit161", 32'(tx_bit_tick), 32'd0);
      goto(320); chk("t1_bit320", 32'(tx_bit_tick), 32'd1);

      // Divisor 4 requested mid-count, applied at the next wrap
      do_reset(1'b1, 1'b0);
      goto(4);   cfg_valid = 1'b1; cfg_div = 16'd4;
      goto(5);   cfg_valid = 1'b0;
      chk("t2_ready5", 32'(cfg_ready), 32'd0);
      chk("t2_div5", 32'(cur_div), 32'd10);
      goto(9);   chk("t2_tick9", 32'(tick_16x), 32'd0);
      goto(10);  chk("t2_tick10", 32'(tick_16x), 32'd1);
      chk("t2_div10", 32'(cur_div), 32'd4);
      chk("t2_ready10", 32'(cfg_ready), 32'd0);
      goto(11);  chk("t2_ready11", 32'(cfg_ready), 32'd1);
      goto(13);  chk("t2_tick13", 32'(tick_16x), 32'd0);
      goto(14);  chk("t2_tick14", 32'(tick_16x), 32'd1);
      goto(18);  chk("t2_tick18", 32'(tick_16x), 32'd1);

      // Rejected divisors, then a transfer coinciding with a wrap
      do_reset(1'b1, 1'b0);
      goto(2);   cfg_valid = 1'b1; cfg_div = 16'd1;
      goto(3);   cfg_valid = 1'b0;
      chk("t3_err1", 32'(cfg_err), 32'd1);
      chk("t3_ready3", 32'(cfg_ready), 32'd1);
      goto(4);   chk("t3_err_clr", 32'(cfg_err), 32'd0);
      cfg_valid = 1'b1; cfg_div = 16'd0;
      goto(5);   cfg_valid = 1'b0;
      chk("t3_err0", 32'(cfg_err), 32'd1);
      goto(6);   chk("t3_err_clr2", 32'(cfg_err), 32'd0);
      chk("t3_div6", 32'(cur_div), 32'd10);
      chk("t3_ready6", 32'(cfg_ready), 32'd1);
      goto(19);  chk("t3_tick19", 32'(tick_16x), 32'd0);
      goto(20);  chk("t3_tick20", 32'(tick_16x), 32'd1);
      goto(29);  cfg_valid = 1'b1; cfg_div = 16'd5;
      goto(30);  cfg_valid = 1'b0;
      chk("t3_tick30", 32'(tick_16x), 32'd1);
      chk("t3_div30", 32'(cur_div), 32'd10);
      chk("t3_ready30", 32'(cfg_ready), 32'd0);
      goto(39);  chk("t3_tick39", 32'(tick_16x), 32'd0);
      goto(40);  chk("t3_tick40", 32'(tick_16x), 32'd1);
      chk("t3_div40", 32'(cur_div), 32'd5);
      goto(41);  chk("t3_ready41", 32'(cfg_ready), 32'd1);
      goto(44);  chk("t3_tick44", 32'(tick_16x), 32'd0);
      goto(45);  chk("t3_tick45", 32'(tick_16x), 32'd1);

      // RX sampling, stop, and re-alignment
      do_reset(1'b1, 1'b1);
      goto(1);   rx_start = 1'b0;
      goto(70);  chk("t4_smp70", 32'(rx_sample_tick), 32'd0);
      goto(80);  chk("t4_smp80", 32'(rx_sample_tick), 32'd1);
      chk("t4_tick80", 32'(tick_16x), 32'd1);
      goto(81);  chk("t4_smp81", 32'(rx_sample_tick), 32'd0);
      goto(240); chk("t4_smp240", 32'(rx_sample_tick), 32'd1);
      goto(400); chk("t4_smp400", 32'(rx_sample_tick), 32'd1);
      rx_stop = 1'b1;
      goto(401); rx_stop = 1'b0;
      goto(560); chk("t4_tick560", 32'(tick_16x), 32'd1);
      chk("t4_smp560", 32'(rx_sample_tick), 32'd0);
      goto(565); rx_start = 1'b1;
      goto(566); rx_start = 1'b0;
      goto(630); chk("t4_smp630", 32'(rx_sample_tick), 32'd0);
      goto(640); chk("t4_smp640", 32'(rx_sample_tick), 32'd1);
      chk("t4_bit640", 32'(tx_bit_tick), 32'd1);

      // Enable low for 25 cycles at cnt=6, then a divisor update while disabled
      do_reset(1'b1, 1'b0);
      goto(10);  chk("t5_tick10", 32'(tick_16x), 32'd1);
      goto(16);  en = 1'b0;
      goto(20);  chk("t5_tick20", 32'(tick_16x), 32'd0);
      goto(41);  en = 1'b1;
      goto(44);  chk("t5_tick44", 32'(tick_16x), 32'd0);
      goto(45);  chk("t5_tick45", 32'(tick_16x), 32'd1);
      goto(175); chk("t5_tick175", 32'(tick_16x), 32'd1);
      chk("t5_bit175", 32'(tx_bit_tick), 32'd0);
      goto(185); chk("t5_bit185", 32'(tx_bit_tick), 32'd1);
      goto(186); en = 1'b0; cfg_valid = 1'b1; cfg_div = 16'd3;
      goto(187); cfg_valid = 1'b0;
      chk("t5_ready187", 32'(cfg_ready), 32'd0);
      chk("t5_tick187", 32'(tick_16x), 32'd0);
      goto(188); chk("t5_div188", 32'(cur_div), 32'd3);
      chk("t5_ready188", 32'(cfg_ready), 32'd0);
      goto(189); chk("t5_ready189", 32'(cfg_ready), 32'd1);
      en = 1'b1;
      goto(191); chk("t5_tick191", 32'(tick_16x), 32'd0);
      goto(192); chk("t5_tick192", 32'(tick_16x), 32'd1);

      // Asynchronous reset mid-period with an update pending and RX running
      do_reset(1'b1, 1'b0);
      goto(10);  chk("t6_tick10", 32'(tick_16x), 32'd1);
      cfg_valid = 1'b1; cfg_div = 16'd7; rx_start = 1'b1;
      goto(11);  cfg_valid = 1'b0; rx_start = 1'b0;
      chk("t6_ready11", 32'(cfg_ready), 32'd0);
      goto(12);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_ready", 32'(cfg_ready), 32'd1);
      chk("t6_async_div", 32'(cur_div), 32'd10);
      chk("t6_async_tick", 32'(tick_16x), 32'd0);
      chk("t6_async_smp", 32'(rx_sample_tick), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1; edge_n = 0;
      goto(9);   chk("t6_tick9", 32'(tick_16x), 32'd0);
      goto(10);  chk("t6_tick10b", 32'(tick_16x), 32'd1);
      goto(20);  chk("t6_div20", 32'(cur_div), 32'd10);
      chk("t6_ready20", 32'(cfg_ready), 32'd1);
      goto(80);  chk("t6_tick80", 32'(tick_16x), 32'd1);
      chk("t6_smp80", 32'(rx_sample_tick), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
